token_bucket_shaper: RTL and testbench



---
 rtl/token_bucket_shaper_pkg.sv | 18 +
 rtl/token_bucket_shaper_if.sv | 21 ++
 rtl/token_bucket_counter.sv | 41 ++++
 rtl/token_bucket_shaper.sv | 54 +++++
 tb/tb_token_bucket_shaper.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/token_bucket_shaper_pkg.sv
// Shared constants and sizing helpers for the token-bucket shaper.
// Used by both the RTL and the bench so the bucket geometry always agrees.
package token_bucket_shaper_pkg;

  localparam int DEF_DEN       = 16;
  localparam int DEF_RATE_NUM  = 3;
  localparam int DEF_BURST_MAX = 8;

  function automatic int tok_max(input int burst, input int den);
    return burst * den;
  endfunction

  // Width must hold tokens + RATE_NUM before the cap is applied.
  function automatic int tok_width(input int tmax, input int rate);
    return $clog2(tmax + rate + 1);
  endfunction

endpackage

// File: rtl/token_bucket_shaper_if.sv
// Request/grant bundle between a requester and the shaper.
// master = requester side, slave = shaper side.
interface token_bucket_shaper_if;

  logic req_i;
  logic grant_o;
  logic ready_o;

  modport master (
    output req_i,
    input  grant_o,
    input  ready_o
  );

  modport slave (
    input  req_i,
    output grant_o,
    output ready_o
  );

endinterface

// File: rtl/token_bucket_counter.sv
// Saturating token accumulator with accrue-then-spend ordering.
// post is the bucket level after this cycle's accrual, before any spend.
module token_bucket_counter
  import token_bucket_shaper_pkg::*;
#(
  parameter int TOK_MAX    = 128,
  parameter int RATE_NUM   = 3,
  parameter int TOKEN_COST = 16,
  parameter int W          = tok_width(TOK_MAX, RATE_NUM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         spend,
  output logic [W-1:0] tokens,
  output logic [W-1:0] post
);

  localparam logic [W-1:0] MAX_K  = W'(TOK_MAX);
  localparam logic [W-1:0] RATE_K = W'(RATE_NUM);
  localparam logic [W-1:0] COST_K = W'(TOKEN_COST);

  logic [W-1:0] sum;

  // Accrue and clip to the bucket depth; excess is discarded.
  always_comb begin
    sum  = tokens + RATE_K;
    post = (sum > MAX_K) ? MAX_K : sum;
  end

  // Bucket starts full; a spend is only requested when post >= cost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tokens <= MAX_K;
    end else if (spend) begin
      tokens <= post - COST_K;
    end else begin
      tokens <= post;
    end
  end

endmodule

// File: rtl/token_bucket_shaper.sv
// Token-bucket rate limiter for a single request stream.
// Refused requests are dropped; the requester holds req_i to retry.
module token_bucket_shaper
  import token_bucket_shaper_pkg::*;
#(
  parameter int DEN        = DEF_DEN,
  parameter int RATE_NUM   = DEF_RATE_NUM,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  parameter int TOKEN_COST = DEN
) (
  input  logic                 clk,
  input  logic                 rst,
  token_bucket_shaper_if.slave bus
);

  localparam int TOK_MAX = tok_max(BURST_MAX, DEN);
  localparam int W       = tok_width(TOK_MAX, RATE_NUM);

  logic [W-1:0] tokens;
  logic [W-1:0] post;
  logic         afford;
  logic         grant;

  token_bucket_counter #(
    .TOK_MAX    (TOK_MAX),
    .RATE_NUM   (RATE_NUM),
    .TOKEN_COST (TOKEN_COST),
    .W          (W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .spend  (grant),
    .tokens (tokens),
    .post   (post)
  );

  // Compare at 32 bits so a cost beyond the counter range never grants.
  always_comb begin
    afford = (32'(post) >= 32'(TOKEN_COST));
    grant  = bus.req_i & afford;
  end

  assign bus.ready_o = afford;

  // One-cycle grant pulse for each request accepted at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant_o <= 1'b0;
    end else begin
      bus.grant_o <= grant;
    end
  end

endmodule

// File: tb/tb_token_bucket_shaper.sv
// Directed and model-checked bench for token_bucket_shaper.
// Default parameters: TOK_MAX = 128, RATE_NUM = 3, TOKEN_COST = 16.
module tb_token_bucket_shaper;

  import token_bucket_shaper_pkg::*;

  localparam int TMAX = tok_max(DEF_BURST_MAX, DEF_DEN);
  localparam int RATE = DEF_RATE_NUM;
  localparam int COST = DEF_DEN;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   m_tok;

  token_bucket_shaper_if bus ();

  token_bucket_shaper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one clock edge of the bucket, returns the grant.
  function automatic logic model_edge(input logic r);
    int p;
    logic g;
    p = m_tok + RATE;
    if (p > TMAX) p = TMAX;
    g = r && (p >= COST);
    m_tok = g ? p - COST : p;
    return g;
  endfunction

  function automatic logic model_ready();
    int p;
    p = m_tok + RATE;
    if (p > TMAX) p = TMAX;
    return p >= COST;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_tok = TMAX;
  endtask

  task automatic test_reset();
    logic [7:0] tk;
    rst = 1'b1;
    bus.req_i = 1'b0;
    step();
    step();
    tk = dut.u_cnt.tokens;
    checks++;
    if (bus.grant_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_grant got=%b want=0", bus.grant_o);
    end
    checks++;
    if (tk !== 8'(TMAX)) begin
      failures++;
      $display("FAIL reset_tokens got=%0d want=%0d", tk, TMAX);
    end
    checks++;
    if (bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", bus.ready_o);
    end
    rst = 1'b0;
    m_tok = TMAX;
  endtask

  task automatic test_idle();
    logic [7:0] tk;
    bus.req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tk = dut.u_cnt.tokens;
      checks++;
      if (bus.grant_o !== 1'b0 || bus.ready_o !== 1'b1 || tk !== 8'd128) begin
        failures++;
        $display("FAIL idle[%0d] got g=%b r=%b t=%0d want g=0 r=1 t=128",
                 i, bus.grant_o, bus.ready_o, tk);
      end
    end
  endtask

  task automatic test_drain();
    logic [7:0] tk;
    logic       eg [12];
    int         et [12];
    eg = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    et = '{112, 99, 86, 73, 60, 47, 34, 21, 8, 11, 14, 1};
    bus.req_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      tk = dut.u_cnt.tokens;
      checks++;
      if (bus.grant_o !== eg[i] || tk !== 8'(et[i])) begin
        failures++;
        $display("FAIL drain[%0d] got g=%b t=%0d want g=%b t=%0d",
                 i + 1, bus.grant_o, tk, eg[i], et[i]);
      end
    end
    m_tok = 1;
  endtask

  task automatic test_refill();
    logic [7:0] tk;
    logic       eg [7];
    int         et [7];
    eg = '{1, 1, 1, 1, 0, 0, 1};
    et = '{48, 35, 22, 9, 12, 15, 2};
    bus.req_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    tk = dut.u_cnt.tokens;
    checks++;
    if (tk !== 8'd61 || bus.grant_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      failures++;
      $display("FAIL refill got t=%0d g=%b r=%b want t=61 g=0 r=1",
               tk, bus.grant_o, bus.ready_o);
    end
    bus.req_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      tk = dut.u_cnt.tokens;
      checks++;
      if (bus.grant_o !== eg[i] || tk !== 8'(et[i])) begin
        failures++;
        $display("FAIL reburst[%0d] got g=%b t=%0d want g=%b t=%0d",
                 i + 1, bus.grant_o, tk, eg[i], et[i]);
      end
    end
    bus.req_i = 1'b0;
    m_tok = 2;
  endtask

  task automatic test_saturation();
    logic [7:0] tk;
    bus.req_i = 1'b0;
    for (int i = 0; i < 50; i++) step();
    tk = dut.u_cnt.tokens;
    checks++;
    if (tk !== 8'd128) begin
      failures++;
      $display("FAIL saturate got t=%0d want t=128", tk);
    end
    m_tok = TMAX;
  endtask

  task automatic test_random();
    logic r;
    logic eg;
    logic er;
    int   bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(99) < 30);
      bus.req_i = r;
      er = model_ready();
      checks++;
      if (bus.ready_o !== er) begin
        failures++;
        bad++;
        $display("FAIL rnd_ready[%0d] got=%b want=%b", i, bus.ready_o, er);
      end
      eg = model_edge(r);
      step();
      checks++;
      if (bus.grant_o !== eg || (bus.grant_o === 1'b1 && !r)) begin
        failures++;
        bad++;
        $display("FAIL rnd_grant[%0d] got=%b want=%b req=%b",
                 i, bus.grant_o, eg, r);
      end
      if (bad > 10) break;
    end
    bus.req_i = 1'b0;
  endtask

  task automatic test_pattern();
    int got;
    int exp;
    int sg;
    int se;
    logic r;
    got = 0;
    exp = 0;
    for (int i = 0; i < 150; i++) begin
      r = (i < 50 || i >= 100);
      bus.req_i = r;
      if (model_edge(r)) exp++;
      step();
      if (bus.grant_o === 1'b1) got++;
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL pattern_count got=%0d want=%0d", got, exp);
    end
    sg = 0;
    se = 0;
    bus.req_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (model_edge(1'b1)) se++;
      step();
      if (bus.grant_o === 1'b1) sg++;
    end
    checks++;
    if (sg !== se || sg < 36 || sg > 40) begin
      failures++;
      $display("FAIL steady_count got=%0d want=%0d (36..40)", sg, se);
    end
    bus.req_i = 1'b0;
  endtask

  task automatic test_midreset();
    logic [7:0] tk;
    apply_reset();
    bus.req_i = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.grant_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_grant got=%b want=1", bus.grant_o);
    end
    #2;
    rst = 1'b1;
    #1;
    tk = dut.u_cnt.tokens;
    checks++;
    if (bus.grant_o !== 1'b0 || tk !== 8'd128) begin
      failures++;
      $display("FAIL async_rst got g=%b t=%0d want g=0 t=128",
               bus.grant_o, tk);
    end
    step();
    rst = 1'b0;
    m_tok = TMAX;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.grant_o !== (i < 9)) begin
        failures++;
        $display("FAIL post_rst[%0d] got=%b want=%b",
                 i + 1, bus.grant_o, (i < 9));
      end
    end
    bus.req_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_tok = TMAX;
    rst = 1'b1;
    bus.req_i = 1'b0;
    test_reset();
    test_idle();
    test_drain();
    test_refill();
    test_saturation();
    test_random();
    test_pattern();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
